mipsfpga_ahb_millis_alarm: RTL and testbench

AHB-Lite responder on the peripheral side of the MIPSfpga bus that reads the free-running millisecond count produced by the millisecond counter and presents it to software. It also provides a compare register, a sticky match flag and a level interrupt. It is a zero-wait-state slave and sits behind the AHB decoder alongside the GPIO slaves.

---
 rtl/mipsfpga_millis_pkg.sv | 19 +
 rtl/mipsfpga_millis_match.sv | 61 ++++++
 rtl/mipsfpga_ahb_millis_alarm.sv | 115 +++++++++++
 tb/tb_mipsfpga_ahb_millis_alarm.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipsfpga_millis_pkg.sv
// Shared register-map constants and the CTRL layout for the AHB millisecond alarm.
package mipsfpga_millis_pkg;

  localparam logic [2:0] IDX_MILLIS   = 3'd0;
  localparam logic [2:0] IDX_COMPARE  = 3'd1;
  localparam logic [2:0] IDX_STATUS   = 3'd2;
  localparam logic [2:0] IDX_CTRL     = 3'd3;
  localparam logic [2:0] IDX_INTERVAL = 3'd4;

  localparam int CTRL_IRQ_EN_BIT      = 0;
  localparam int CTRL_PERIODIC_EN_BIT = 1;
  localparam int STATUS_MATCH_BIT     = 0;

  typedef struct packed {
    logic periodicEn;
    logic irqEn;
  } ctrl_t;

endpackage

// File: rtl/mipsfpga_millis_match.sv
// Match detection on each millisecond step, sticky MATCH flag, COMPARE register
// with optional periodic reload, and the registered alarm interrupt.
module mipsfpga_millis_match
  import mipsfpga_millis_pkg::*;
#(
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] millis_i,
  input  logic        compareWe_i,
  input  logic [31:0] compareWdata_i,
  input  logic        statusClr_i,
  input  ctrl_t       ctrlNext_i,
  input  logic [31:0] interval_i,
  output logic [31:0] compare_o,
  output logic        match_o,
  output logic        irq_o
);

  logic [31:0] millis_q;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic        irq_q;
  logic        matchEvent;

  // Only a count step can fire, and it is judged against COMPARE before any
  // bus write this cycle; a bus write beats a reload, a match beats a W1C.
  always_comb begin
    matchEvent = (millis_i != millis_q) && (millis_i == compare_q);
    compare_d  = compare_q;
    if (compareWe_i)
      compare_d = compareWdata_i;
    else if (matchEvent && ctrlNext_i.periodicEn)
      compare_d = compare_q + interval_i;
    match_d = match_q;
    if (statusClr_i)
      match_d = 1'b0;
    if (matchEvent)
      match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      millis_q  <= 32'd0;
      compare_q <= COMPARE_RST;
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      millis_q  <= millis_i;
      compare_q <= compare_d;
      match_q   <= match_d;
      irq_q     <= match_d & ctrlNext_i.irqEn;
    end
  end

  assign compare_o = compare_q;
  assign match_o   = match_q;
  assign irq_o     = irq_q;

endmodule

// File: rtl/mipsfpga_ahb_millis_alarm.sv
// Zero-wait AHB-Lite slave exposing the millisecond count, COMPARE/STATUS/CTRL and,
// when MILLIS_ALARM_PERIODIC_EN is defined, INTERVAL with periodic COMPARE reload.
module mipsfpga_ahb_millis_alarm
  import mipsfpga_millis_pkg::*;
#(
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] millis,
  input  logic        HSEL,
  input  logic [4:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        irq
);

  logic        dpValid_q;
  logic        dpWrite_q;
  logic [2:0]  dpIdx_q;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] intervalVal;
  logic [31:0] compareVal;
  logic        matchVal;
  logic        wrEn;
  logic        unusedBits;

  assign unusedBits = ^{HADDR[1:0], HTRANS[0]};
  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;
  assign wrEn       = dpValid_q & dpWrite_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dpValid_q <= 1'b0;
      dpWrite_q <= 1'b0;
      dpIdx_q   <= 3'd0;
    end else begin
      dpValid_q <= HSEL & HTRANS[1] & HREADY;
      dpWrite_q <= HWRITE;
      dpIdx_q   <= HADDR[4:2];
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wrEn && dpIdx_q == IDX_CTRL) begin
      ctrl_d.irqEn = HWDATA[CTRL_IRQ_EN_BIT];
`ifdef MILLIS_ALARM_PERIODIC_EN
      ctrl_d.periodicEn = HWDATA[CTRL_PERIODIC_EN_BIT];
`endif
    end
`ifndef MILLIS_ALARM_PERIODIC_EN
    ctrl_d.periodicEn = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset)
      ctrl_q <= '0;
    else
      ctrl_q <= ctrl_d;
  end

`ifdef MILLIS_ALARM_PERIODIC_EN
  logic [31:0] interval_q;

  always_ff @(posedge clk) begin
    if (reset)
      interval_q <= 32'd0;
    else if (wrEn && dpIdx_q == IDX_INTERVAL)
      interval_q <= HWDATA;
  end

  assign intervalVal = interval_q;
`else
  assign intervalVal = 32'd0;
`endif

  mipsfpga_millis_match #(
    .COMPARE_RST(COMPARE_RST)
  ) u_match (
    .clk           (clk),
    .reset         (reset),
    .millis_i      (millis),
    .compareWe_i   (wrEn && dpIdx_q == IDX_COMPARE),
    .compareWdata_i(HWDATA),
    .statusClr_i   (wrEn && dpIdx_q == IDX_STATUS && HWDATA[STATUS_MATCH_BIT]),
    .ctrlNext_i    (ctrl_d),
    .interval_i    (intervalVal),
    .compare_o     (compareVal),
    .match_o       (matchVal),
    .irq_o         (irq)
  );

  always_comb begin
    HRDATA = 32'd0;
    if (dpValid_q) begin
      case (dpIdx_q)
        IDX_MILLIS:   HRDATA = millis;
        IDX_COMPARE:  HRDATA = compareVal;
        IDX_STATUS:   HRDATA[STATUS_MATCH_BIT] = matchVal;
        IDX_CTRL:     HRDATA[1:0] = ctrl_q;
        IDX_INTERVAL: HRDATA = intervalVal;
        default:      HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mipsfpga_ahb_millis_alarm.sv
// Directed bench for the AHB millisecond alarm; covers both builds of MILLIS_ALARM_PERIODIC_EN.
module tb_mipsfpga_ahb_millis_alarm;

  logic        clk;
  logic        reset;
  logic [31:0] millis;
  logic        HSEL;
  logic [4:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

`ifdef MILLIS_ALARM_PERIODIC_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  typedef struct {
    bit          isWrite;
    logic [2:0]  idx;
    logic [31:0] wdata;
    logic [31:0] millisVal;
    logic [31:0] expRdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  mipsfpga_ahb_millis_alarm #(
    .COMPARE_RST(32'hFFFF_FFFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .millis   (millis),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HREADY   (HREADY),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = 5'd0;
  endtask

  task automatic addrPhase(input bit wr, input logic [2:0] idx);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HADDR  = {idx, 2'b00};
  endtask

  task automatic busWrite(input logic [2:0] idx, input logic [31:0] data);
    addrPhase(1'b1, idx);
    tick();
    idleBus();
    HWDATA = data;
    tick();
  endtask

  task automatic busRead(input logic [2:0] idx, output logic [31:0] data);
    addrPhase(1'b0, idx);
    tick();
    idleBus();
    data = HRDATA;
    tick();
  endtask

  task automatic readCheck(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    busRead(idx, d);
    checkOutput(name, d, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    millis = v.millisVal;
    if (v.isWrite)
      busWrite(v.idx, v.wdata);
    else
      readCheck(v.name, v.idx, v.expRdata);
    checkOutput("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    checkOutput("hresp", {31'd0, HRESP}, 32'd0);
  endtask

  function automatic vec_t mkVec(input bit w, input logic [2:0] idx, input logic [31:0] wd,
                                 input logic [31:0] mv, input logic [31:0] exp, input string name);
    vec_t v;
    v.isWrite   = w;
    v.idx       = idx;
    v.wdata     = wd;
    v.millisVal = mv;
    v.expRdata  = exp;
    v.name      = name;
    return v;
  endfunction

  initial begin
    vecs.push_back(mkVec(0, 3'd0, 0, 32'h0000_0100, 32'h0000_0100, "rst_millis"));
    vecs.push_back(mkVec(0, 3'd1, 0, 32'h0000_0100, 32'hFFFF_FFFF, "rst_compare"));
    vecs.push_back(mkVec(0, 3'd2, 0, 32'h0000_0100, 32'h0, "rst_status"));
    vecs.push_back(mkVec(0, 3'd3, 0, 32'h0000_0100, 32'h0, "rst_ctrl"));
    vecs.push_back(mkVec(0, 3'd4, 0, 32'h0000_0100, 32'h0, "rst_interval"));
    vecs.push_back(mkVec(0, 3'd5, 0, 32'h0000_0100, 32'h0, "rst_idx5"));
    vecs.push_back(mkVec(0, 3'd6, 0, 32'h0000_0100, 32'h0, "rst_idx6"));
    vecs.push_back(mkVec(0, 3'd7, 0, 32'h0000_0100, 32'h0, "rst_idx7"));
    vecs.push_back(mkVec(1, 3'd1, 32'hA5A5_0F0F, 32'h0000_0100, 0, "wr_compare"));
    vecs.push_back(mkVec(0, 3'd1, 0, 32'h0000_0100, 32'hA5A5_0F0F, "rd_compare"));
    vecs.push_back(mkVec(1, 3'd5, 32'hDEAD_BEEF, 32'h0000_0100, 0, "wr_idx5"));
    vecs.push_back(mkVec(0, 3'd5, 0, 32'h0000_0100, 32'h0, "rd_idx5"));
    vecs.push_back(mkVec(1, 3'd3, 32'hFFFF_FFFF, 32'h0000_0100, 0, "wr_ctrl_all"));
    vecs.push_back(mkVec(0, 3'd3, 0, 32'h0000_0100, PERIODIC ? 32'd3 : 32'd1, "rd_ctrl_all"));
    vecs.push_back(mkVec(1, 3'd3, 32'h0, 32'h0000_0100, 0, "wr_ctrl_0"));
    vecs.push_back(mkVec(0, 3'd3, 0, 32'h0000_0100, 32'h0, "rd_ctrl_0"));
    vecs.push_back(mkVec(1, 3'd4, 32'd7, 32'h0000_0100, 0, "wr_interval"));
    vecs.push_back(mkVec(0, 3'd4, 0, 32'h0000_0100, PERIODIC ? 32'd7 : 32'd0, "rd_interval"));
    vecs.push_back(mkVec(1, 3'd2, 32'hFFFF_FFFF, 32'h0000_0100, 0, "wr_status"));
    vecs.push_back(mkVec(0, 3'd2, 0, 32'h0000_0100, 32'h0, "rd_status"));
    vecs.push_back(mkVec(0, 3'd0, 0, 32'h1234_5678, 32'h1234_5678, "rd_millis_live"));

    reset  = 1'b1;
    millis = 32'h0000_0100;
    HREADY = 1'b1;
    HWDATA = 32'd0;
    idleBus();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("idle_hrdata", HRDATA, 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // One-shot alarm: single trigger, no re-trigger while millis holds.
    millis = 32'd3;
    busWrite(3'd1, 32'd5);
    busWrite(3'd3, 32'd1);
    millis = 32'd4;
    tick();
    checkOutput("irq_before_match", {31'd0, irq}, 32'd0);
    millis = 32'd5;
    tick();
    checkOutput("irq_on_match", {31'd0, irq}, 32'd1);
    readCheck("status_on_match", 3'd2, 32'd1);
    repeat (10) tick();
    checkOutput("irq_held", {31'd0, irq}, 32'd1);
    busWrite(3'd2, 32'd1);
    checkOutput("irq_after_w1c", {31'd0, irq}, 32'd0);
    repeat (10) tick();
    checkOutput("irq_no_retrigger", {31'd0, irq}, 32'd0);
    readCheck("status_no_retrigger", 3'd2, 32'd0);
    readCheck("compare_oneshot", 3'd1, 32'd5);

`ifdef MILLIS_ALARM_PERIODIC_EN
    busWrite(3'd4, 32'd10);
    busWrite(3'd1, 32'hFFFF_FFFA);
    busWrite(3'd3, 32'd3);
    for (logic [31:0] m = 32'hFFFF_FFF8; m != 32'hFFFF_FFFB; m++) begin
      millis = m;
      tick();
    end
    checkOutput("per_irq_1", {31'd0, irq}, 32'd1);
    readCheck("per_compare_4", 3'd1, 32'd4);
    busWrite(3'd2, 32'd1);
    for (logic [31:0] m = 32'hFFFF_FFFB; m != 32'd4; m++) begin
      millis = m;
      tick();
    end
    checkOutput("per_irq_quiet", {31'd0, irq}, 32'd0);
    millis = 32'd4;
    tick();
    checkOutput("per_irq_2", {31'd0, irq}, 32'd1);
    readCheck("per_compare_14", 3'd1, 32'd14);
`else
    busWrite(3'd3, 32'd3);
    readCheck("ctrl_no_periodic", 3'd3, 32'd1);
    busWrite(3'd1, 32'hFFFF_FFFA);
    millis = 32'hFFFF_FFF9;
    tick();
    millis = 32'hFFFF_FFFA;
    tick();
    checkOutput("np_irq", {31'd0, irq}, 32'd1);
    readCheck("np_compare_kept", 3'd1, 32'hFFFF_FFFA);
    readCheck("np_interval", 3'd4, 32'd0);
`endif
    busWrite(3'd2, 32'd1);
    busWrite(3'd3, 32'd1);

    // Wrap onto COMPARE=0, then IRQ_EN gating of a sticky MATCH.
    busWrite(3'd1, 32'd0);
    millis = 32'hFFFF_FFFF;
    tick();
    checkOutput("wrap_irq_pre", {31'd0, irq}, 32'd0);
    millis = 32'd0;
    tick();
    checkOutput("wrap_irq", {31'd0, irq}, 32'd1);
    busWrite(3'd3, 32'd0);
    checkOutput("irqen_off", {31'd0, irq}, 32'd0);
    readCheck("status_kept", 3'd2, 32'd1);
    busWrite(3'd3, 32'd1);
    checkOutput("irqen_on", {31'd0, irq}, 32'd1);
    busWrite(3'd2, 32'd1);

    // W1C in the same cycle millis steps onto COMPARE: the set wins.
    millis = 32'd19;
    busWrite(3'd1, 32'd20);
    addrPhase(1'b1, 3'd2);
    tick();
    idleBus();
    HWDATA = 32'd1;
    millis = 32'd20;
    tick();
    checkOutput("race_irq", {31'd0, irq}, 32'd1);
    readCheck("race_status", 3'd2, 32'd1);
    busWrite(3'd2, 32'd1);
    checkOutput("race_irq_clr", {31'd0, irq}, 32'd0);
    readCheck("race_status_clr", 3'd2, 32'd0);

    // Back-to-back write then read of COMPARE.
    millis = 32'd100;
    addrPhase(1'b1, 3'd1);
    tick();
    HWDATA = 32'h0000_1234;
    addrPhase(1'b0, 3'd1);
    tick();
    idleBus();
    checkOutput("b2b_compare", HRDATA, 32'h0000_1234);
    tick();

    // Transfer in flight at reset is dropped.
    addrPhase(1'b0, 3'd0);
    reset = 1'b1;
    tick();
    idleBus();
    reset = 1'b0;
    checkOutput("reset_drop_hrdata", HRDATA, 32'd0);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    readCheck("reset_compare", 3'd1, 32'hFFFF_FFFF);
    readCheck("reset_ctrl", 3'd3, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
